// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - LED sequencer states, mode encodings and pattern tables
package led_seq_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam logic [1:0] MODE_UP    = 2'd0;
  localparam logic [1:0] MODE_DOWN  = 2'd1;
  localparam logic [1:0] MODE_WALK  = 2'd2;
  localparam logic [1:0] MODE_BLINK = 2'd3;

  localparam int PAT_LEN_UP    = 16;
  localparam int PAT_LEN_DOWN  = 16;
  localparam int PAT_LEN_WALK  = 4;
  localparam int PAT_LEN_BLINK = 2;

  function automatic logic [3:0] pattern(input logic [1:0] mode, input logic [3:0] step);
    logic [3:0] val;
    case (mode)
      MODE_UP:   val = step;
      MODE_DOWN: val = 4'hF - step;
      MODE_WALK: val = 4'b0001 << step[1:0];
      default:   val = step[0] ? 4'hF : 4'h0;
    endcase
    return val;
  endfunction

  function automatic logic [3:0] last_step(input logic [1:0] mode);
    logic [3:0] val;
    case (mode)
      MODE_UP:   val = 4'(PAT_LEN_UP - 1);
      MODE_DOWN: val = 4'(PAT_LEN_DOWN - 1);
      MODE_WALK: val = 4'(PAT_LEN_WALK - 1);
      default:   val = 4'(PAT_LEN_BLINK - 1);
    endcase
    return val;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - prescaler producing one tick every CLK_DIV enabled cycles
// tick is combinational on the final count so the step advances on the same edge the count wraps.
module led_tick_gen #(
  parameter int unsigned CLK_DIV = 25_000_000
) (
  input  logic clk_50Mhz,
  input  logic res_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  assign tick = en && !clr && (cnt_q == LAST);

  always_ff @(posedge clk_50Mhz or negedge res_n) begin
    if (!res_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// rtl/led_seq_ctrl.sv - 4-bit LED pattern sequencer with command handshake
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int unsigned CLK_DIV = 25_000_000
) (
  input  logic       clk_50Mhz,
  input  logic       res_n,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [1:0] cfg_mode,
  input  logic [7:0] cfg_reps,
  input  logic       pause,
  input  logic       stop,
  output logic [3:0] LED,
  output logic       busy,
  output logic       tick,
  output logic       done
);

  logic       state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [7:0] reps_q, reps_d;
  logic [3:0] step_q, step_d;
  logic [7:0] pass_q, pass_d;
  logic [3:0] led_q, led_d;
  logic       done_q, done_d;
  logic       run, accept, tick_raw, adv, final_pass;

  assign run       = (state_q == ST_RUN);
  assign cfg_ready = (state_q == ST_IDLE);
  assign busy      = run;
  assign accept    = cfg_valid && cfg_ready && !stop;
  assign tick      = tick_raw && !stop;
  assign adv       = run && tick;
  assign final_pass = (reps_q != 8'd0) && (pass_q == reps_q - 8'd1);

  led_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_50Mhz (clk_50Mhz),
    .res_n     (res_n),
    .en        (run && !pause),
    .clr       (!run || stop),
    .tick      (tick_raw)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    reps_d  = reps_q;
    step_d  = step_q;
    pass_d  = pass_q;
    led_d   = led_q;
    done_d  = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
      led_d   = 4'h0;
    end else if (accept) begin
      state_d = ST_RUN;
      mode_d  = cfg_mode;
      reps_d  = cfg_reps;
      step_d  = 4'h0;
      pass_d  = 8'd0;
      led_d   = pattern(cfg_mode, 4'h0);
    end else if (adv) begin
      if (step_q == last_step(mode_q)) begin
        if (final_pass) begin
          // LED keeps the last pattern value after the final pass
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          step_d = 4'h0;
          pass_d = (pass_q == 8'hFF) ? pass_q : pass_q + 8'd1;
          led_d  = pattern(mode_q, 4'h0);
        end
      end else begin
        step_d = step_q + 4'd1;
        led_d  = pattern(mode_q, step_q + 4'd1);
      end
    end
  end

  always_ff @(posedge clk_50Mhz or negedge res_n) begin
    if (!res_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_UP;
      reps_q  <= 8'd0;
      step_q  <= 4'h0;
      pass_q  <= 8'd0;
      led_q   <= 4'h0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      reps_q  <= reps_d;
      step_q  <= step_d;
      pass_q  <= pass_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

  assign LED  = led_q;
  assign done = done_q;

endmodule
